avalon_bus_arbiter: RTL and testbench

//   Two-master, one-slave arbiter for the 32-bit Avalon memory-mapped bus. Lets the CPU
//   (master 0) and a second requester such as a loader or DMA (master 1) share one memory

---
 rtl/avalon_bus_arbiter_if.sv | 21 ++
 rtl/avalon_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_avalon_bus_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/avalon_bus_arbiter_if.sv
// One Avalon-MM port: address/control/write data flow master->slave, stall and read data flow back.
// Each master port and the slave port of the arbiter gets its own instance.
interface avalon_bus_arbiter_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/avalon_bus_arbiter.sv
// Two-master round-robin Avalon-MM arbiter with bounded owner hold; a request seen in IDLE reaches the slave next cycle.
// Slave waitrequest passes straight to the owner; the non-owner is held with waitrequest=1 until granted.
module avalon_bus_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  avalon_bus_arbiter_if.slave  m0,
  avalon_bus_arbiter_if.slave  m1,
  avalon_bus_arbiter_if.master s,
  output logic [1:0]           grant
);

  localparam int HCW = $clog2(MAX_HOLD) + 1;

  typedef enum logic {IDLE, OWN} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [1:0]       grant_q, grant_d;

  logic req0, req1, req_own, req_oth, done;

  assign req0    = m0.read | m0.write;
  assign req1    = m1.read | m1.write;
  assign req_own = owner_q ? req1 : req0;
  assign req_oth = owner_q ? req0 : req1;
  assign done    = (state_q == OWN) && req_own && !s.waitrequest;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        if (req0 && req1) begin
          state_d = OWN;
          owner_d = ~last_q;
        end else if (req0) begin
          state_d = OWN;
          owner_d = 1'b0;
        end else if (req1) begin
          state_d = OWN;
          owner_d = 1'b1;
        end
      end
      OWN: begin
        if (!req_own) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end else if (done) begin
          last_d = owner_q;
          // Handover happens straight from OWN so the waiting master sees no idle bubble.
          if (req_oth) begin
            owner_d    = ~owner_q;
            hold_cnt_d = '0;
          end else if (hold_cnt_q == HCW'(MAX_HOLD - 1)) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HCW'(1);
          end
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
    endcase
    grant_d = (state_d == OWN) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      hold_cnt_q <= '0;
      grant_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
    end
  end

  assign grant = grant_q;

  // Slave mux keys off the registered grant, so an async reset clears the bus in the same cycle.
  always_comb begin
    s.address    = '0;
    s.read       = 1'b0;
    s.write      = 1'b0;
    s.writedata  = '0;
    s.byteenable = '0;
    if (grant_q[0]) begin
      s.address    = m0.address;
      s.read       = m0.read;
      s.write      = m0.write;
      s.writedata  = m0.writedata;
      s.byteenable = m0.byteenable;
    end else if (grant_q[1]) begin
      s.address    = m1.address;
      s.read       = m1.read;
      s.write      = m1.write;
      s.writedata  = m1.writedata;
      s.byteenable = m1.byteenable;
    end
  end

  assign m0.waitrequest = grant_q[0] ? s.waitrequest : 1'b1;
  assign m1.waitrequest = grant_q[1] ? s.waitrequest : 1'b1;
  assign m0.readdata    = s.readdata;
  assign m1.readdata    = s.readdata;

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed bench for avalon_bus_arbiter: inputs change on the falling edge, outputs are checked 1ns later.
module tb_avalon_bus_arbiter;
  logic       clk;
  logic       reset;
  logic [1:0] grant;
  int         errors;
  int         checks;

  avalon_bus_arbiter_if m0_bus ();
  avalon_bus_arbiter_if m1_bus ();
  avalon_bus_arbiter_if s_bus ();

  avalon_bus_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus),
    .grant (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {grant[1:0], m1_waitrequest, m0_waitrequest, s_read, s_write}
  localparam logic [5:0] CTL_IDLE = 6'b00_1_1_0_0;

  function automatic logic [5:0] ctl();
    return {grant, m1_bus.waitrequest, m0_bus.waitrequest, s_bus.read, s_bus.write};
  endfunction

  task automatic clear_inputs();
    m0_bus.address = '0; m0_bus.read = 0; m0_bus.write = 0; m0_bus.writedata = '0; m0_bus.byteenable = '0;
    m1_bus.address = '0; m1_bus.read = 0; m1_bus.write = 0; m1_bus.writedata = '0; m1_bus.byteenable = '0;
    s_bus.waitrequest = 0; s_bus.readdata = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 0;
    clear_inputs();
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    clear_inputs();
    m0_bus.read = 1; m0_bus.address = 32'h1234_5678; m0_bus.byteenable = 4'hF;
    m1_bus.write = 1; m1_bus.writedata = 32'hDEAD_BEEF; m1_bus.byteenable = 4'h3;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ctl() !== CTL_IDLE) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), CTL_IDLE); end
    checks++;
    if ({s_bus.address, s_bus.writedata, s_bus.byteenable} !== 68'h0) begin
      errors++; $display("FAIL reset_bus got addr=%h wd=%h be=%h exp all zero", s_bus.address, s_bus.writedata, s_bus.byteenable);
    end
    apply_reset();
  endtask

  task automatic test_single_read();
    @(negedge clk);
    m0_bus.read = 1; m0_bus.address = 32'hBFC0_0000; m0_bus.byteenable = 4'hF;
    s_bus.waitrequest = 0; s_bus.readdata = 32'h1234_5678;
    #1;
    checks++;
    if (ctl() !== CTL_IDLE) begin errors++; $display("FAIL rd_cycle1 got=%b exp=%b", ctl(), CTL_IDLE); end
    @(negedge clk); #1;
    checks++;
    if (ctl() !== 6'b01_1_0_1_0) begin errors++; $display("FAIL rd_cycle2 got=%b exp=%b", ctl(), 6'b01_1_0_1_0); end
    checks++;
    if ({s_bus.address, s_bus.byteenable} !== {32'hBFC0_0000, 4'hF}) begin
      errors++; $display("FAIL rd_addr got=%h/%h exp=bfc00000/f", s_bus.address, s_bus.byteenable);
    end
    checks++;
    if ({m0_bus.readdata, m1_bus.readdata} !== {32'h1234_5678, 32'h1234_5678}) begin
      errors++; $display("FAIL rd_data got=%h/%h exp=12345678", m0_bus.readdata, m1_bus.readdata);
    end
    @(negedge clk);
    m0_bus.read = 0;
    @(negedge clk); #1;
    checks++;
    if (ctl() !== CTL_IDLE) begin errors++; $display("FAIL rd_release got=%b exp=%b", ctl(), CTL_IDLE); end
  endtask

  task automatic test_tie_handover();
    apply_reset();
    m0_bus.read = 1; m0_bus.address = 32'h0000_00A0;
    m1_bus.write = 1; m1_bus.address = 32'h0000_00A1; m1_bus.writedata = 32'h5555_AAAA; m1_bus.byteenable = 4'hC;
    s_bus.waitrequest = 1;
    @(negedge clk); #1;
    checks++;
    if (ctl() !== 6'b01_1_1_1_0 || s_bus.address !== 32'hA0) begin
      errors++; $display("FAIL tie_m0_stall got=%b/%h exp=%b/a0", ctl(), s_bus.address, 6'b01_1_1_1_0);
    end
    @(negedge clk); s_bus.waitrequest = 0; #1;
    checks++;
    if (ctl() !== 6'b01_1_0_1_0) begin errors++; $display("FAIL tie_m0_done got=%b exp=%b", ctl(), 6'b01_1_0_1_0); end
    @(negedge clk); m0_bus.read = 0; s_bus.waitrequest = 1; #1;
    checks++;
    if (ctl() !== 6'b10_1_1_0_1) begin errors++; $display("FAIL tie_m1_stall got=%b exp=%b", ctl(), 6'b10_1_1_0_1); end
    checks++;
    if ({s_bus.address, s_bus.writedata, s_bus.byteenable} !== {32'hA1, 32'h5555_AAAA, 4'hC}) begin
      errors++; $display("FAIL tie_m1_bus got=%h/%h/%h exp=a1/5555aaaa/c", s_bus.address, s_bus.writedata, s_bus.byteenable);
    end
    @(negedge clk); s_bus.waitrequest = 0; #1;
    checks++;
    if (ctl() !== 6'b10_0_1_0_1) begin errors++; $display("FAIL tie_m1_done got=%b exp=%b", ctl(), 6'b10_0_1_0_1); end
    @(negedge clk); m1_bus.write = 0;
    @(negedge clk); #1;
    checks++;
    if (ctl() !== CTL_IDLE) begin errors++; $display("FAIL tie_idle got=%b exp=%b", ctl(), CTL_IDLE); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_grant [8];
    int done;
    exp_grant = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01};
    done = 0;
    for (int n = 0; n < 8; n++) begin
      if (n != 0) @(negedge clk);
      m0_bus.address = 32'h100 + 32'(4 * done);
      m0_bus.read = (done < 6);
      #1;
      checks++;
      if (grant !== exp_grant[n]) begin errors++; $display("FAIL b2b_grant cyc=%0d got=%b exp=%b", n, grant, exp_grant[n]); end
      if (!m0_bus.waitrequest) begin
        checks++;
        if (s_bus.address !== 32'h100 + 32'(4 * done) || s_bus.read !== 1'b1) begin
          errors++; $display("FAIL b2b_xfer k=%0d got=%h/%b exp=%h/1", done, s_bus.address, s_bus.read, 32'h100 + 32'(4 * done));
        end
        done++;
      end
    end
    checks++;
    if (done !== 6) begin errors++; $display("FAIL b2b_count got=%0d exp=6", done); end
    @(negedge clk); m0_bus.read = 0;
    @(negedge clk);
  endtask

  task automatic test_stall_hold();
    @(negedge clk);
    m1_bus.write = 1; m1_bus.address = 32'h2000; m1_bus.writedata = 32'hCAFE_F00D; m1_bus.byteenable = 4'hF;
    s_bus.waitrequest = 1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      m0_bus.read = 1; m0_bus.address = 32'h3000;
      #1;
      checks++;
      if (ctl() !== 6'b10_1_1_0_1 || s_bus.address !== 32'h2000 || s_bus.writedata !== 32'hCAFE_F00D) begin
        errors++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%h exp=%b/2000/cafef00d", n, ctl(), s_bus.address, s_bus.writedata, 6'b10_1_1_0_1);
      end
    end
    @(negedge clk); s_bus.waitrequest = 0; #1;
    checks++;
    if (ctl() !== 6'b10_0_1_0_1) begin errors++; $display("FAIL stall_done got=%b exp=%b", ctl(), 6'b10_0_1_0_1); end
    @(negedge clk); m1_bus.write = 0; #1;
    checks++;
    if (ctl() !== 6'b01_1_0_1_0 || s_bus.address !== 32'h3000) begin
      errors++; $display("FAIL stall_m0_next got=%b/%h exp=%b/3000", ctl(), s_bus.address, 6'b01_1_0_1_0);
    end
    @(negedge clk); m0_bus.read = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk);
    m1_bus.write = 1; m1_bus.address = 32'h4000; m1_bus.writedata = 32'h0BAD_F00D;
    s_bus.waitrequest = 1;
    @(negedge clk);
    m0_bus.read = 1; m0_bus.address = 32'h5000;
    #1;
    checks++;
    if (ctl() !== 6'b10_1_1_0_1) begin errors++; $display("FAIL rst_pre got=%b exp=%b", ctl(), 6'b10_1_1_0_1); end
    #1 reset = 0;
    #1;
    checks++;
    if (ctl() !== CTL_IDLE || s_bus.address !== 32'h0) begin
      errors++; $display("FAIL rst_async got=%b/%h exp=%b/0", ctl(), s_bus.address, CTL_IDLE);
    end
    @(negedge clk); reset = 1; #1;
    checks++;
    if (ctl() !== CTL_IDLE) begin errors++; $display("FAIL rst_release got=%b exp=%b", ctl(), CTL_IDLE); end
    @(negedge clk); #1;
    checks++;
    if (ctl() !== 6'b01_1_1_1_0 || s_bus.address !== 32'h5000) begin
      errors++; $display("FAIL rst_tie got=%b/%h exp=%b/5000", ctl(), s_bus.address, 6'b01_1_1_1_0);
    end
    @(negedge clk); clear_inputs();
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_read();
    test_tie_handover();
    test_back_to_back();
    test_stall_hold();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
